// File: rtl/voxel_traversal_unit_v2_if.sv
`default_nettype none
// ============================================================================
// Module      : voxel_traversal_unit_v2_if
// Description : Voxel memory port. The traversal unit is the master: it
//               issues one block-coordinate read and waits for exactly one
//               block-type response per accepted request.
// Revision    : 1.0  initial release
// ============================================================================
interface voxel_traversal_unit_v2_if #(
  parameter int COORD_W = 8,
  parameter int BLOCK_W = 4
);
  logic                 mem_req_valid;
  logic                 mem_req_ready;
  logic [3*COORD_W-1:0] mem_addr;
  logic                 mem_rsp_valid;
  logic [BLOCK_W-1:0]   mem_rsp_data;

  modport master (
    output mem_req_valid,
    output mem_addr,
    input  mem_req_ready,
    input  mem_rsp_valid,
    input  mem_rsp_data
  );

  modport slave (
    input  mem_req_valid,
    input  mem_addr,
    output mem_req_ready,
    output mem_rsp_valid,
    output mem_rsp_data
  );
endinterface
`default_nettype wire

// File: rtl/voxel_traversal_unit_v2.sv
`default_nettype none
// ============================================================================
// Module      : voxel_traversal_unit_v2
// Description : DDA voxel ray caster. Walks one ray through a bounded world,
//               fetching each visited block over a variable-latency memory
//               port, and reports HIT / EXIT / LIMIT with position, entry
//               face, and face-entry distance t.
// Revision    : 1.0  initial release
// ============================================================================
module voxel_traversal_unit_v2 #(
  parameter int W         = 32,
  parameter int F         = 16,
  parameter int COORD_W   = 8,
  parameter int BLOCK_W   = 4,
  parameter int WORLD_X   = 64,
  parameter int WORLD_Y   = 64,
  parameter int WORLD_Z   = 64,
  parameter int MAX_STEPS = 60
) (
  input  wire                       clk_in,
  input  wire                       rst_n_in,
  input  wire                       start_valid,
  output logic                      start_ready,
  input  wire  [3*W-1:0]            ray_origin,
  input  wire  [3*W-1:0]            ray_inv_dir,
  input  wire  [2:0]                ray_dir_neg,
  input  wire                       abort,
  voxel_traversal_unit_v2_if.master mem,
  output logic                      res_valid,
  input  wire                       res_ready,
  output logic [1:0]                res_status,
  output logic [BLOCK_W-1:0]        res_block,
  output logic [3*COORD_W-1:0]      res_pos,
  output logic [1:0]                res_axis,
  output logic                      res_norm_neg,
  output logic [W-1:0]              res_t
);

  localparam int              c_SW        = $clog2(MAX_STEPS + 1);
  localparam logic [W-1:0]    c_SAT       = {1'b0, {(W-1){1'b1}}};
  localparam logic [F:0]      c_ONE       = {1'b1, {F{1'b0}}};
  localparam logic [c_SW-1:0] c_MAX_STEPS = c_SW'(MAX_STEPS);
  localparam logic [1:0]      c_ST_HIT    = 2'd0;
  localparam logic [1:0]      c_ST_EXIT   = 2'd1;
  localparam logic [1:0]      c_ST_LIMIT  = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_QUERY, S_WAIT, S_STEP, S_DONE, S_DRAIN
  } state_t;

  // Per-axis arrays are indexed 0 = x, 1 = y, 2 = z.
  state_t                    r_state;
  logic signed [COORD_W-1:0] r_pos  [3];
  logic [W-1:0]              r_inv  [3];
  logic [W-1:0]              r_tmax [3];
  logic [F:0]                r_dist [3];
  logic [2:0]                r_neg;
  logic [c_SW-1:0]           r_steps;
  logic                      r_start_ready;
  logic                      r_req_valid;
  logic [3*COORD_W-1:0]      r_addr;
  logic                      r_res_valid;
  logic [1:0]                r_status;
  logic [BLOCK_W-1:0]        r_block;
  logic [1:0]                r_axis;
  logic                      r_norm_neg;
  logic [W-1:0]              r_t;

  logic [F-1:0]              w_frac      [3];
  logic signed [COORD_W-1:0] w_floor     [3];
  logic [F:0]                w_dist_in   [3];
  logic [2*W-1:0]            w_prod      [3];
  logic [W-1:0]              w_tmax_init [3];
  logic [W:0]                w_sum       [3];
  logic [W-1:0]              w_tmax_adv  [3];
  logic signed [COORD_W-1:0] w_next_pos  [3];
  logic [1:0]                w_sel;
  logic                      w_cur_inb;
  logic                      w_next_inb;
  logic                      w_unused;

  // Inside the world means 0..WORLD-1 on every axis, treating coords as signed.
  function automatic logic f_in_world(input logic signed [COORD_W-1:0] x,
                                      input logic signed [COORD_W-1:0] y,
                                      input logic signed [COORD_W-1:0] z);
    return (int'(x) >= 0) && (int'(x) < WORLD_X) &&
           (int'(y) >= 0) && (int'(y) < WORLD_Y) &&
           (int'(z) >= 0) && (int'(z) < WORLD_Z);
  endfunction

  // Ray decode, initial t_max products, saturating t_max advance, axis choice
  always_comb begin
    for (int a = 0; a < 3; a++) begin
      w_frac[a]    = ray_origin[(2-a)*W +: F];
      w_floor[a]   = ray_origin[(2-a)*W + F +: COORD_W];
      w_dist_in[a] = ray_dir_neg[2-a] ? {1'b0, w_frac[a]} : (c_ONE - {1'b0, w_frac[a]});
      w_prod[a]    = {{W{1'b0}}, r_inv[a]} * {{(2*W-F-1){1'b0}}, r_dist[a]};
      // A product with any bit at or above the sign position after >>F saturates.
      if ((r_inv[a] == c_SAT) || (|w_prod[a][2*W-1:W-1+F]))
        w_tmax_init[a] = c_SAT;
      else
        w_tmax_init[a] = w_prod[a][F +: W];
      w_sum[a]      = {1'b0, r_tmax[a]} + {1'b0, r_inv[a]};
      w_tmax_adv[a] = (w_sum[a][W] || w_sum[a][W-1]) ? c_SAT : w_sum[a][W-1:0];
      w_next_pos[a] = r_pos[a];
    end
    if ((r_tmax[0] < r_tmax[1]) && (r_tmax[0] < r_tmax[2]))
      w_sel = 2'd0;
    else if (r_tmax[1] < r_tmax[2])
      w_sel = 2'd1;
    else
      w_sel = 2'd2;
    w_next_pos[w_sel] = r_pos[w_sel] + (r_neg[w_sel] ? {COORD_W{1'b1}} : COORD_W'(1));
    w_cur_inb  = f_in_world(r_pos[0], r_pos[1], r_pos[2]);
    w_next_inb = f_in_world(w_next_pos[0], w_next_pos[1], w_next_pos[2]);
  end

  // Integer bits of the origin above the coordinate field and the fraction
  // bits dropped by the >>F are intentionally discarded.
  assign w_unused = ^{ray_origin, w_prod[0], w_prod[1], w_prod[2]};

  // Traversal state machine; every output comes straight from a register
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state       <= S_IDLE;
      for (int a = 0; a < 3; a++) begin
        r_pos[a]  <= '0;
        r_inv[a]  <= '0;
        r_tmax[a] <= '0;
        r_dist[a] <= '0;
      end
      r_neg         <= '0;
      r_steps       <= '0;
      r_start_ready <= 1'b0;
      r_req_valid   <= 1'b0;
      r_addr        <= '0;
      r_res_valid   <= 1'b0;
      r_status      <= '0;
      r_block       <= '0;
      r_axis        <= '0;
      r_norm_neg    <= 1'b0;
      r_t           <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_valid && r_start_ready) begin
            r_start_ready <= 1'b0;
            for (int a = 0; a < 3; a++) begin
              r_pos[a]  <= w_floor[a];
              r_inv[a]  <= ray_inv_dir[(2-a)*W +: W];
              r_dist[a] <= w_dist_in[a];
            end
            r_neg   <= {ray_dir_neg[0], ray_dir_neg[1], ray_dir_neg[2]};
            r_state <= S_SETUP;
          end else begin
            r_start_ready <= 1'b1;
          end
        end

        S_SETUP: begin
          if (abort) begin
            r_start_ready <= 1'b1;
            r_state       <= S_IDLE;
          end else begin
            for (int a = 0; a < 3; a++) r_tmax[a] <= w_tmax_init[a];
            r_steps     <= '0;
            r_axis      <= 2'd0;
            r_t         <= '0;
            r_norm_neg  <= 1'b0;
            r_block     <= '0;
            r_status    <= '0;
            // Request is raised on QUERY entry only if the block is in the world.
            r_req_valid <= w_cur_inb;
            r_addr      <= {r_pos[0], r_pos[1], r_pos[2]};
            r_state     <= S_QUERY;
          end
        end

        S_QUERY: begin
          if (abort) begin
            r_req_valid <= 1'b0;
            if (r_req_valid && mem.mem_req_ready) begin
              r_state <= S_DRAIN;
            end else begin
              r_start_ready <= 1'b1;
              r_state       <= S_IDLE;
            end
          end else if (!r_req_valid) begin
            r_status    <= c_ST_EXIT;
            r_res_valid <= 1'b1;
            r_state     <= S_DONE;
          end else if (mem.mem_req_ready) begin
            r_req_valid <= 1'b0;
            r_state     <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (abort) begin
            // A response landing in the abort cycle closes the transaction.
            if (mem.mem_rsp_valid) begin
              r_start_ready <= 1'b1;
              r_state       <= S_IDLE;
            end else begin
              r_state <= S_DRAIN;
            end
          end else if (mem.mem_rsp_valid) begin
            if (mem.mem_rsp_data != '0) begin
              r_block     <= mem.mem_rsp_data;
              r_status    <= c_ST_HIT;
              r_res_valid <= 1'b1;
              r_state     <= S_DONE;
            end else if (r_steps == c_MAX_STEPS) begin
              r_status    <= c_ST_LIMIT;
              r_res_valid <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_state <= S_STEP;
            end
          end
        end

        S_STEP: begin
          if (abort) begin
            r_start_ready <= 1'b1;
            r_state       <= S_IDLE;
          end else begin
            r_t            <= r_tmax[w_sel];
            r_tmax[w_sel]  <= w_tmax_adv[w_sel];
            for (int a = 0; a < 3; a++) r_pos[a] <= w_next_pos[a];
            r_axis         <= w_sel + 2'd1;
            // Stepping toward +axis enters through the face whose normal is -axis.
            r_norm_neg     <= ~r_neg[w_sel];
            r_steps        <= r_steps + c_SW'(1);
            r_req_valid    <= w_next_inb;
            r_addr         <= {w_next_pos[0], w_next_pos[1], w_next_pos[2]};
            r_state        <= S_QUERY;
          end
        end

        S_DONE: begin
          if (res_ready) begin
            r_res_valid   <= 1'b0;
            r_start_ready <= 1'b1;
            r_state       <= S_IDLE;
          end
        end

        S_DRAIN: begin
          if (mem.mem_rsp_valid) begin
            r_start_ready <= 1'b1;
            r_state       <= S_IDLE;
          end
        end

        default: begin
          r_req_valid   <= 1'b0;
          r_res_valid   <= 1'b0;
          r_start_ready <= 1'b0;
          r_state       <= S_IDLE;
        end
      endcase
    end
  end

  assign start_ready       = r_start_ready;
  assign mem.mem_req_valid = r_req_valid;
  assign mem.mem_addr      = r_addr;
  assign res_valid         = r_res_valid;
  assign res_status        = r_status;
  assign res_block         = r_block;
  assign res_pos           = {r_pos[0], r_pos[1], r_pos[2]};
  assign res_axis          = r_axis;
  assign res_norm_neg      = r_norm_neg;
  assign res_t             = r_t;

endmodule
`default_nettype wire

// File: tb/tb_voxel_traversal_unit_v2.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_voxel_traversal_unit_v2
// Description : Directed bench for the voxel traversal unit with a
//               configurable stall / latency memory responder.
// Revision    : 1.0  initial release
// ============================================================================
module tb_voxel_traversal_unit_v2;

  localparam int          W    = 32;
  localparam int          CW   = 8;
  localparam int          BW   = 4;
  localparam logic [W-1:0] ONE  = 32'h0001_0000;
  localparam logic [W-1:0] HALF = 32'h0000_8000;
  localparam logic [W-1:0] P2_5 = 32'h0002_8000;
  localparam logic [W-1:0] MAXV = 32'h7FFF_FFFF;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start_valid = 1'b0;
  logic             start_ready;
  logic [3*W-1:0]   ray_origin = '0;
  logic [3*W-1:0]   ray_inv_dir = '0;
  logic [2:0]       ray_dir_neg = '0;
  logic             abort = 1'b0;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [1:0]       res_status;
  logic [BW-1:0]    res_block;
  logic [3*CW-1:0]  res_pos;
  logic [1:0]       res_axis;
  logic             res_norm_neg;
  logic [W-1:0]     res_t;

  int n_checks = 0;
  int n_errors = 0;

  voxel_traversal_unit_v2_if #(.COORD_W(CW), .BLOCK_W(BW)) mem_if ();

  voxel_traversal_unit_v2 #(
    .W(W), .F(16), .COORD_W(CW), .BLOCK_W(BW),
    .WORLD_X(64), .WORLD_Y(64), .WORLD_Z(64), .MAX_STEPS(4)
  ) dut (
    .clk_in       (clk),
    .rst_n_in     (rst_n),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .ray_origin   (ray_origin),
    .ray_inv_dir  (ray_inv_dir),
    .ray_dir_neg  (ray_dir_neg),
    .abort        (abort),
    .mem          (mem_if),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_status   (res_status),
    .res_block    (res_block),
    .res_pos      (res_pos),
    .res_axis     (res_axis),
    .res_norm_neg (res_norm_neg),
    .res_t        (res_t)
  );

  always #5 clk = ~clk;

  // ---------------- memory responder (acts on falling edges) ----------------
  bit          cfg_solid   = 1'b0;
  int          cfg_stall   = 0;
  int          cfg_lat_min = 1;
  int          cfg_lat_max = 1;
  int          req_count   = 0;
  int          addr_changes = 0;
  logic [23:0] req_log [0:255];
  bit          m_prev_ready = 1'b0;
  bit          m_prev_valid = 1'b0;
  logic [23:0] m_prev_addr  = '0;
  int          m_rsp_cnt    = 0;
  int          m_stall_cnt  = 0;
  logic [3:0]  m_rsp_data   = '0;

  initial begin
    mem_if.mem_req_ready = 1'b0;
    mem_if.mem_rsp_valid = 1'b0;
    mem_if.mem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      mem_if.mem_rsp_valid = 1'b0;
      if (!rst_n) begin
        m_rsp_cnt = 0; m_stall_cnt = 0;
        m_prev_ready = 1'b0; m_prev_valid = 1'b0;
        mem_if.mem_req_ready = 1'b0;
      end else begin
        if (m_prev_ready && m_prev_valid) begin
          if (req_count < 256) req_log[req_count] = m_prev_addr;
          req_count++;
          m_rsp_data = (cfg_solid && m_prev_addr == 24'h05_02_02) ? 4'd3 : 4'd0;
          m_rsp_cnt  = int'($urandom_range(cfg_lat_max, cfg_lat_min));
        end else if (m_prev_valid && mem_if.mem_req_valid && mem_if.mem_addr !== m_prev_addr) begin
          addr_changes++;
        end
        if (m_rsp_cnt > 0) begin
          m_rsp_cnt--;
          if (m_rsp_cnt == 0) begin
            mem_if.mem_rsp_valid = 1'b1;
            mem_if.mem_rsp_data  = m_rsp_data;
          end
        end
        if (mem_if.mem_req_valid) begin
          if (m_stall_cnt < cfg_stall) begin
            mem_if.mem_req_ready = 1'b0;
            m_stall_cnt++;
          end else begin
            mem_if.mem_req_ready = 1'b1;
          end
        end else begin
          mem_if.mem_req_ready = 1'b0;
          m_stall_cnt = 0;
        end
        m_prev_ready = mem_if.mem_req_ready;
        m_prev_valid = mem_if.mem_req_valid;
        m_prev_addr  = mem_if.mem_addr;
      end
    end
  end

  // ---------------- stimulus helpers (no checking inside) ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic start_ray(input logic [3*W-1:0] org, input logic [3*W-1:0] inv,
                           input logic [2:0] neg);
    int n;
    n = 0;
    while (start_ready !== 1'b1 && n < 50) begin tick(); n++; end
    if (start_ready !== 1'b1) begin
      n_checks++; n_errors++;
      $display("FAIL start_timeout: start_ready=%b, required 1", start_ready);
    end
    start_valid = 1'b1;
    ray_origin  = org;
    ray_inv_dir = inv;
    ray_dir_neg = neg;
    tick();
    start_valid = 1'b0;
  endtask

  task automatic wait_result(input int budget, output bit got);
    int n;
    n = 0;
    while (res_valid !== 1'b1 && n < budget) begin tick(); n++; end
    got = (res_valid === 1'b1);
  endtask

  task automatic consume();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (start_ready !== 1'b0 || res_valid !== 1'b0 || mem_if.mem_req_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_handshakes: start_ready=%b res_valid=%b req_valid=%b, required 0 0 0",
               start_ready, res_valid, mem_if.mem_req_valid);
    end
    n_checks++;
    if ({res_status, res_block, res_pos, res_axis, res_norm_neg, res_t} !== '0) begin
      n_errors++;
      $display("FAIL reset_results: status=%0d block=%0d pos=%h axis=%0d nn=%b t=%h, required all 0",
               res_status, res_block, res_pos, res_axis, res_norm_neg, res_t);
    end
    rst_n = 1'b1;
    tick(); tick();
    n_checks++;
    if (start_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_idle_ready: start_ready=%b, required 1", start_ready);
    end
  endtask

  task automatic test_hit();
    bit got;
    int base;
    cfg_solid = 1'b1; cfg_stall = 0; cfg_lat_min = 1; cfg_lat_max = 1;
    base = req_count;
    start_ray({P2_5, P2_5, P2_5}, {ONE, MAXV, MAXV}, 3'b000);
    wait_result(200, got);
    n_checks++;
    if (!got) begin n_errors++; $display("FAIL hit_timeout: res_valid=%b, required 1", res_valid); end
    n_checks++;
    if (res_status !== 2'd0 || res_block !== 4'd3) begin
      n_errors++;
      $display("FAIL hit_status: status=%0d block=%0d, required 0 3", res_status, res_block);
    end
    n_checks++;
    if (res_pos !== 24'h05_02_02 || res_axis !== 2'd1 || res_norm_neg !== 1'b1) begin
      n_errors++;
      $display("FAIL hit_face: pos=%h axis=%0d nn=%b, required 050202 1 1", res_pos, res_axis, res_norm_neg);
    end
    n_checks++;
    if (res_t !== 32'h0002_8000) begin
      n_errors++; $display("FAIL hit_t: t=%h, required 00028000", res_t);
    end
    n_checks++;
    if (req_count - base !== 4) begin
      n_errors++; $display("FAIL hit_requests: %0d, required 4", req_count - base);
    end
    consume();
    n_checks++;
    if (res_valid !== 1'b0) begin
      n_errors++; $display("FAIL hit_release: res_valid=%b, required 0", res_valid);
    end
  endtask

  task automatic test_limit();
    bit got;
    int base;
    cfg_solid = 1'b0; cfg_stall = 0; cfg_lat_min = 1; cfg_lat_max = 1;
    base = req_count;
    start_ray({P2_5, P2_5, P2_5}, {ONE, MAXV, MAXV}, 3'b000);
    wait_result(200, got);
    n_checks++;
    if (!got || res_status !== 2'd2 || res_block !== 4'd0) begin
      n_errors++;
      $display("FAIL limit_status: valid=%b status=%0d block=%0d, required 1 2 0", res_valid, res_status, res_block);
    end
    n_checks++;
    if (req_count - base !== 5) begin
      n_errors++; $display("FAIL limit_requests: %0d, required 5", req_count - base);
    end
    n_checks++;
    if (res_pos !== 24'h06_02_02 || res_axis !== 2'd1 || res_t !== 32'h0003_8000) begin
      n_errors++;
      $display("FAIL limit_pos: pos=%h axis=%0d t=%h, required 060202 1 00038000", res_pos, res_axis, res_t);
    end
    consume();
  endtask

  task automatic test_exit();
    bit got;
    int base;
    cfg_solid = 1'b0; cfg_stall = 0; cfg_lat_min = 1; cfg_lat_max = 1;
    base = req_count;
    start_ray({HALF, HALF, HALF}, {ONE, MAXV, MAXV}, 3'b100);
    wait_result(200, got);
    n_checks++;
    if (!got || res_status !== 2'd1) begin
      n_errors++; $display("FAIL exit_status: valid=%b status=%0d, required 1 1", res_valid, res_status);
    end
    n_checks++;
    if (req_count - base !== 1) begin
      n_errors++; $display("FAIL exit_requests: %0d, required 1", req_count - base);
    end
    n_checks++;
    if (res_pos !== 24'hFF_00_00 || res_axis !== 2'd1 || res_norm_neg !== 1'b0 || res_t !== 32'h0000_8000) begin
      n_errors++;
      $display("FAIL exit_face: pos=%h axis=%0d nn=%b t=%h, required ff0000 1 0 00008000",
               res_pos, res_axis, res_norm_neg, res_t);
    end
    consume();
  endtask

  task automatic test_diagonal();
    bit got;
    int base;
    logic [23:0] exp_log [5];
    exp_log = '{24'h00_00_00, 24'h00_00_01, 24'h00_01_01, 24'h01_01_01, 24'h01_01_02};
    cfg_solid = 1'b0; cfg_stall = 0; cfg_lat_min = 1; cfg_lat_max = 1;
    base = req_count;
    start_ray({HALF, HALF, HALF}, {ONE, ONE, ONE}, 3'b000);
    wait_result(200, got);
    n_checks++;
    if (!got || res_status !== 2'd2 || req_count - base !== 5) begin
      n_errors++;
      $display("FAIL diag_limit: valid=%b status=%0d requests=%0d, required 1 2 5",
               res_valid, res_status, req_count - base);
    end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (req_log[base + i] !== exp_log[i]) begin
        n_errors++;
        $display("FAIL diag_order[%0d]: addr=%h, required %h", i, req_log[base + i], exp_log[i]);
      end
    end
    n_checks++;
    if (res_pos !== 24'h01_01_02 || res_axis !== 2'd3 || res_norm_neg !== 1'b1 || res_t !== 32'h0001_8000) begin
      n_errors++;
      $display("FAIL diag_face: pos=%h axis=%0d nn=%b t=%h, required 010102 3 1 00018000",
               res_pos, res_axis, res_norm_neg, res_t);
    end
    consume();
  endtask

  task automatic test_stall_latency();
    bit got;
    int base;
    int chg;
    cfg_solid = 1'b1; cfg_stall = 5; cfg_lat_min = 1; cfg_lat_max = 20;
    base = req_count;
    chg  = addr_changes;
    start_ray({P2_5, P2_5, P2_5}, {ONE, MAXV, MAXV}, 3'b000);
    wait_result(600, got);
    n_checks++;
    if (!got || res_status !== 2'd0 || res_block !== 4'd3) begin
      n_errors++;
      $display("FAIL stall_status: valid=%b status=%0d block=%0d, required 1 0 3", res_valid, res_status, res_block);
    end
    n_checks++;
    if (res_pos !== 24'h05_02_02 || res_axis !== 2'd1 || res_norm_neg !== 1'b1 || res_t !== 32'h0002_8000) begin
      n_errors++;
      $display("FAIL stall_face: pos=%h axis=%0d nn=%b t=%h, required 050202 1 1 00028000",
               res_pos, res_axis, res_norm_neg, res_t);
    end
    n_checks++;
    if (addr_changes - chg !== 0 || req_count - base !== 4) begin
      n_errors++;
      $display("FAIL stall_addr_stable: changes=%0d requests=%0d, required 0 4", addr_changes - chg, req_count - base);
    end
    consume();
    cfg_stall = 0; cfg_lat_min = 1; cfg_lat_max = 1;
  endtask

  task automatic test_abort_drain();
    bit got;
    int base;
    int n;
    logic [W-1:0] t_held;
    cfg_solid = 1'b1; cfg_stall = 0; cfg_lat_min = 7; cfg_lat_max = 7;
    base = req_count;
    start_ray({P2_5, P2_5, P2_5}, {ONE, MAXV, MAXV}, 3'b000);
    n = 0;
    while (req_count == base && n < 50) begin tick(); n++; end
    n_checks++;
    if (req_count == base) begin n_errors++; $display("FAIL abort_no_request: requests=0, required 1"); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    // Response is still several cycles away: the unit must be draining.
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (start_ready !== 1'b0 || res_valid !== 1'b0) begin
        n_errors++;
        $display("FAIL abort_drain[%0d]: start_ready=%b res_valid=%b, required 0 0", i, start_ready, res_valid);
      end
      tick();
    end
    n = 0;
    while (start_ready !== 1'b1 && n < 30) begin
      if (res_valid === 1'b1) begin
        n_checks++; n_errors++;
        $display("FAIL abort_result: res_valid=%b, required 0", res_valid);
      end
      tick(); n++;
    end
    n_checks++;
    if (start_ready !== 1'b1 || req_count - base !== 1) begin
      n_errors++;
      $display("FAIL abort_idle: start_ready=%b requests=%0d, required 1 1", start_ready, req_count - base);
    end
    cfg_lat_min = 1; cfg_lat_max = 1;
    start_ray({P2_5, P2_5, P2_5}, {ONE, MAXV, MAXV}, 3'b000);
    wait_result(200, got);
    n_checks++;
    if (!got || res_status !== 2'd0 || res_pos !== 24'h05_02_02 || res_t !== 32'h0002_8000) begin
      n_errors++;
      $display("FAIL after_abort_hit: valid=%b status=%0d pos=%h t=%h, required 1 0 050202 00028000",
               res_valid, res_status, res_pos, res_t);
    end
    t_held = res_t;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++;
      if (res_valid !== 1'b1 || start_ready !== 1'b0 || res_t !== t_held || res_block !== 4'd3) begin
        n_errors++;
        $display("FAIL hold_result[%0d]: valid=%b start_ready=%b t=%h block=%0d, required 1 0 %h 3",
                 i, res_valid, start_ready, res_t, res_block, t_held);
      end
    end
    consume();
    n_checks++;
    if (res_valid !== 1'b0) begin
      n_errors++; $display("FAIL hold_release: res_valid=%b, required 0", res_valid);
    end
  endtask

  initial begin
    test_reset();
    test_hit();
    test_limit();
    test_exit();
    test_diagonal();
    test_stall_latency();
    test_abort_drain();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
